arbiter_nm: RTL

- Parametrised successor to the two-master serial-bus arbiter. Arbitrates NUM_MASTERS bus masters onto the shared serial bus.
- Arbitration is fixed-priority or round-robin, selected by parameter.
- Supports one outstanding split transaction to the split-capable slave. Adds a split-timeout abort and a release-hold that waits for slave readiness.
- Sits between the master ports and the bus mux; drives grants, mux select and per-master split flags.

---
 rtl/arbiter_nm_pkg.sv | 22 ++
 rtl/rr_pick.sv | 31 +++
 rtl/arbiter_nm.sv | 132 +++++++++++++
 3 files changed

// File: rtl/arbiter_nm_pkg.sv
// Shared types and helpers for the N-master serial-bus arbiter.
package arbiter_nm_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_GRANT
    } state_t;

    localparam int MAX_MASTERS = 16;
    // Split timeout counter width; SPLIT_TIMEOUT must fit in this many bits.
    localparam int SPLIT_CNT_W = 16;

    function automatic logic [3:0] onehot_to_idx(input logic [MAX_MASTERS-1:0] vec);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_MASTERS; i++) begin
            if (vec[i]) idx = idx | 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational picker: lowest index wins (mode=0) or first index after ptr (mode=1).
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    input  logic         mode,
    output logic [N-1:0] gnt,
    output logic [W-1:0] idx,
    output logic         valid
);

    int cand;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        cand  = 0;
        for (int k = 0; k < N; k++) begin
            cand = mode ? (int'(ptr) + 1 + k) % N : k;
            if (!valid && req[cand]) begin
                valid     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = W'(cand);
            end
        end
    end

endmodule

// File: rtl/arbiter_nm.sv
// N-master bus arbiter with one outstanding split, split timeout and sready release hold.
module arbiter_nm
    import arbiter_nm_pkg::*;
#(
    parameter int NUM_MASTERS   = 2,
    parameter int NUM_SLAVES    = 3,
    parameter int RR_MODE       = 0,
    parameter int SPLIT_TIMEOUT = 256,
    parameter int MSEL_W        = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_MASTERS-1:0] breq,
    input  logic [NUM_SLAVES-1:0]  sready,
    input  logic                   sreadysp,
    input  logic                   ssplit,
    output logic [NUM_MASTERS-1:0] bgrant,
    output logic [MSEL_W-1:0]      msel,
    output logic [NUM_MASTERS-1:0] msplit,
    output logic                   split_grant,
    output logic                   split_abort
);

    state_t                 state, state_n;
    logic [NUM_MASTERS-1:0] bgrant_n, msplit_n, eligible, pick_gnt;
    logic [MSEL_W-1:0]      msel_n, rr_ptr, rr_ptr_n, pick_idx, split_idx;
    logic [SPLIT_CNT_W-1:0] cnt, cnt_n;
    logic                   pick_valid, split_active, resume_ok, resume_now, owner_resumed;
    logic                   split_grant_n, split_abort_n;

    assign eligible     = breq & ~msplit;
    assign split_active = |msplit;
    assign split_idx    = MSEL_W'(onehot_to_idx(MAX_MASTERS'(msplit)));

    rr_pick #(
        .N(NUM_MASTERS),
        .W(MSEL_W)
    ) u_pick (
        .req  (eligible),
        .ptr  (rr_ptr),
        .mode (RR_MODE != 0),
        .gnt  (pick_gnt),
        .idx  (pick_idx),
        .valid(pick_valid)
    );

    always_comb begin
        state_n       = state;
        bgrant_n      = bgrant;
        msel_n        = msel;
        msplit_n      = msplit;
        rr_ptr_n      = rr_ptr;
        cnt_n         = cnt;
        split_grant_n = 1'b0;
        split_abort_n = 1'b0;

        resume_ok     = split_active && |(breq & msplit) && sreadysp && !ssplit;
        resume_now    = (state == ST_IDLE) && resume_ok;
        owner_resumed = (state == ST_GRANT) && split_active && (msel == split_idx);

        case (state)
            ST_IDLE: begin
                if (resume_now) begin
                    state_n  = ST_GRANT;
                    bgrant_n = msplit;
                    msel_n   = split_idx;
                end else if (pick_valid) begin
                    state_n  = ST_GRANT;
                    bgrant_n = pick_gnt;
                    msel_n   = pick_idx;
                end
                if (RR_MODE != 0 && state_n == ST_GRANT) rr_ptr_n = msel_n;
            end
            ST_GRANT: begin
                if (ssplit && !split_active) begin
                    state_n  = ST_IDLE;
                    bgrant_n = '0;
                    msel_n   = '0;
                    msplit_n = bgrant;
                    cnt_n    = '0;
                end else if (!breq[msel] && &sready) begin
                    state_n  = ST_IDLE;
                    bgrant_n = '0;
                    msel_n   = '0;
                end
            end
            default: begin
                state_n  = ST_IDLE;
                bgrant_n = '0;
                msel_n   = '0;
            end
        endcase

        // A resume being granted this edge takes precedence over a timeout expiring on it.
        if (owner_resumed) begin
            msplit_n      = '0;
            split_grant_n = 1'b1;
            cnt_n         = '0;
        end else if (split_active && SPLIT_TIMEOUT != 0 && !resume_now) begin
            if (cnt == SPLIT_CNT_W'(SPLIT_TIMEOUT - 1)) begin
                msplit_n      = '0;
                split_abort_n = 1'b1;
                cnt_n         = '0;
            end else begin
                cnt_n = cnt + SPLIT_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            bgrant      <= '0;
            msel        <= '0;
            msplit      <= '0;
            split_grant <= 1'b0;
            split_abort <= 1'b0;
            rr_ptr      <= MSEL_W'(NUM_MASTERS - 1);
            cnt         <= '0;
        end else begin
            state       <= state_n;
            bgrant      <= bgrant_n;
            msel        <= msel_n;
            msplit      <= msplit_n;
            split_grant <= split_grant_n;
            split_abort <= split_abort_n;
            rr_ptr      <= rr_ptr_n;
            cnt         <= cnt_n;
        end
    end

endmodule
